uart_arbiter: RTL



---
 rtl/uart_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_arbiter.sv
// rtl/uart_arbiter.sv - round-robin owner arbiter for the shared UART with a mux settle cycle
// Optional idle-owner timeout with requester blocking: define UART_ARB_TIMEOUT_EN.
`ifndef CpuNumWidth
`define CpuNumWidth 2
`endif

module uart_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu0_req,
    input  logic                    cpu1_req,
    input  logic                    cpu2_req,
    input  logic                    cpu0_uart_act,
    input  logic                    cpu1_uart_act,
    input  logic                    cpu2_uart_act,
    output logic [`CpuNumWidth-1:0] cpu_uart_num,
    output logic                    cpu0_gnt,
    output logic                    cpu1_gnt,
    output logic                    cpu2_gnt,
    output logic                    arb_busy,
    output logic                    arb_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] NUM_NONE = 2'b11;

    state_t     state_q;
    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic [1:0] num_q;
    logic [2:0] gnt_q;
    logic       busy_q;

    logic [2:0] req;
    logic [2:0] act;
    logic [2:0] elig;
    logic       owner_req;
    logic       owner_act;
    logic [1:0] rr_win_d;
    logic       rr_vld_d;
    logic [1:0] cand;

    assign req       = {cpu2_req, cpu1_req, cpu0_req};
    assign act       = {cpu2_uart_act, cpu1_uart_act, cpu0_uart_act};
    assign owner_req = req[owner_q];
    assign owner_act = act[owner_q];

    function automatic logic [1:0] next_cpu(input logic [1:0] n);
        return (n == 2'd2) ? 2'd0 : n + 2'd1;
    endfunction

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       block_q;
    logic             timeout_q;

    assign elig        = req & ~block_q;
    assign arb_timeout = timeout_q;
`else
    logic unused_act;

    assign unused_act  = owner_act;
    assign elig        = req;
    assign arb_timeout = 1'b0;
`endif

    // Scan the three CPUs in order starting just after the previous owner.
    always_comb begin
        rr_win_d = 2'd0;
        rr_vld_d = 1'b0;
        cand     = next_cpu(last_q);
        for (int k = 0; k < 3; k++) begin
            if (!rr_vld_d && elig[cand]) begin
                rr_win_d = cand;
                rr_vld_d = 1'b1;
            end
            cand = next_cpu(cand);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            num_q   <= NUM_NONE;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            block_q   <= 3'b000;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            block_q   <= block_q & req;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (rr_vld_d) begin
                        state_q <= ST_SETUP;
                        owner_q <= rr_win_d;
                        num_q   <= rr_win_d;
                        busy_q  <= 1'b1;
                    end
                end
                // Select already reached the mux; grant only once it has settled.
                ST_SETUP: begin
                    if (owner_req) begin
                        state_q <= ST_OWN;
                        gnt_q   <= 3'b001 << owner_q;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        state_q <= ST_RELEASE;
                        num_q   <= NUM_NONE;
                        last_q  <= owner_q;
                    end
                end
                ST_OWN: begin
                    if (!owner_req) begin
                        state_q <= ST_RELEASE;
                        gnt_q   <= 3'b000;
                        num_q   <= NUM_NONE;
                        last_q  <= owner_q;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (owner_act) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q          <= ST_RELEASE;
                        gnt_q            <= 3'b000;
                        num_q            <= NUM_NONE;
                        last_q           <= owner_q;
                        timeout_q        <= 1'b1;
                        block_q[owner_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    num_q   <= NUM_NONE;
                    gnt_q   <= 3'b000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_uart_num = num_q;
    assign cpu0_gnt     = gnt_q[0];
    assign cpu1_gnt     = gnt_q[1];
    assign cpu2_gnt     = gnt_q[2];
    assign arb_busy     = busy_q;

endmodule
